organization_stage_mt: RTL
==========================

// Module: organization_stage_mt
// PURPOSE
// Multi-thread successor of the single-thread organization stage. Parks up to NUM_THREADS
// issued thread programs, matches read returns from NUM_RET return channels by receive_id,
// and emits one merged pipeline_pass_structure per cycle to execution over valid/ready.
// Sits between thread scheduler/memory read ports and the execution pipeline.
// PARAMETERS
// NUM_THREADS  8  parking slots, one per thread_id (thread_id_t must cover 0..NUM_THREADS-1)
// NUM_RET      2  parallel read-return channels
// PORTS
// clk            in   1                  clock
// rst            in   1                  reset, synchronous, active-low
// issue_valid    in   1                  issue request
// issue_ready    out  1                  slot for issue_id is FREE
// issue_thread   in   thread_program_stuct_t  thread + instuctions to park
// issue_id       in   thread_id_t        slot index
// issue_need_data in  1                  1: wait for read return; 0: complete at issue
// ret            in   read_return_t[NUM_RET]  valid/data/read_address/receive_id per channel
// out_valid      out  1                  out_ev holds a merged entry
// out_ready      in   1                  execution accepts out_ev
// out_ev         out  pipeline_pass_structure  merged entry
// err_orphan     out  1                  pulse: return dropped (id not WAIT, or duplicate)
// pending_count  out  $clog2(NUM_THREADS+1)  slots not FREE
// BEHAVIOUR
// - Reset (rst==0 at posedge): all slots FREE, out_valid=0, out_ev='0, err_orphan=0,
//   pending_count=0, arbiter pointer=0. Reset mid-operation discards all parked/held entries.
// - Slot FSM per id: FREE -issue,need_data=1-> WAIT; FREE -issue,need_data=0-> DONE;
//   WAIT -matching return-> DONE; DONE -granted to output reg-> FREE.
// - issue_ready = (slot[issue_id]==FREE); issue fires on issue_valid&&issue_ready only.
// - Return accepted if ret[c].valid and slot[receive_id]==WAIT; captures data, read_address.
// - Return in same cycle as issue to same id with need_data=1: accepted (bypass), slot -> DONE.
// - Multiple valid returns to same id in one cycle: lowest channel wins, rest dropped.
// - Dropped return (any reason): err_orphan=1 for exactly the next cycle; ORed across channels.
// - Output register: loads when !out_valid || out_ready; round-robin among DONE slots,
//   starting at id after last grant. Held stable while out_valid && !out_ready.
// - Latency: issue(need_data=0) at edge N -> out_valid at edge N+1 earliest;
//   return at edge N -> out_valid at edge N+1 earliest. Throughput 1 entry/cycle.
// - out_ev fields: thread, instuctions from slot; data/data_address = captured or 0 when
//   need_data=0; system.active_thread=1; system.id=slot index.
// - Granted slot becomes FREE at the grant edge; may be reissued in the same cycle? No:
//   issue_ready uses registered state, so reissue earliest one cycle after grant.
// - pending_count = registered count of WAIT+DONE slots; never exceeds NUM_THREADS.
// STRUCTURE
// - EV_types: add org_slot_state_e {SLOT_FREE, SLOT_WAIT, SLOT_DONE} and org_slot_t
//   (state, thread_program_stuct_t, data, read_address). Existing read_return_t,
//   pipeline_pass_structure, thread_id_t stay in DataInterface_pkg/EV_types.
// - Sub-module rr_arbiter #(N): request vector, advance enable -> one-hot grant, pointer reg.
// TESTING
// - Issue id 3, need_data=0, out_ready=1 -> out_valid next cycle, id=3, data=0, addr=0.
// - Issue id 2 need_data=1; 5 cycles later ret[1]{id=2,data=0xABCD,addr=0x40} ->
//   out_ev.data=0xABCD, data_address=0x40, pending_count 1->0.
// - ret[0] for id 5 while slot FREE -> no output, err_orphan=1 one cycle; ret[0]&ret[1]
//   both id 2 (WAIT) -> ch0 data used, err_orphan=1.
// - Slots 1,4,6 DONE, out_ready low 3 cycles then high -> out_ev stable while stalled,
//   emission order 1,4,6; then 4 more DONE -> round-robin wrap verified.
// - Fill all 8 slots -> issue_ready=0 for every id, pending_count=8; assert rst=0 mid-stall
//   -> next cycle out_valid=0, pending_count=0, issue_ready=1.
// - Issue id 0 need_data=1 with same-cycle ret{id=0} -> accepted, out_valid next cycle.

Source files
------------

// File: rtl/organization_stage_mt_pkg.sv
// Shared types for the multi-thread organization stage: the thread program, read return and
// pipeline pass layouts, plus the per-slot parking record.
package organization_stage_mt_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;
  localparam int TID_W   = 3;

  typedef logic [TID_W-1:0] thread_id_t;

  typedef struct packed {
    logic [7:0]         thread;
    logic [INSTR_W-1:0] instuctions;
  } thread_program_stuct_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] read_address;
    thread_id_t        receive_id;
  } read_return_t;

  typedef struct packed {
    logic       active_thread;
    thread_id_t id;
  } system_t;

  typedef struct packed {
    system_t            system;
    logic [7:0]         thread;
    logic [INSTR_W-1:0] instuctions;
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  data_address;
  } pipeline_pass_structure;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_WAIT,
    SLOT_DONE
  } org_slot_state_e;

  typedef struct packed {
    org_slot_state_e       state;
    thread_program_stuct_t prog;
    logic [DATA_W-1:0]     data;
    logic [ADDR_W-1:0]     read_address;
  } org_slot_t;

  function automatic pipeline_pass_structure build_pass(
    input thread_program_stuct_t prog,
    input logic [DATA_W-1:0]     data,
    input logic [ADDR_W-1:0]     addr,
    input thread_id_t            id
  );
    pipeline_pass_structure p;
    p.system.active_thread = 1'b1;
    p.system.id            = id;
    p.thread               = prog.thread;
    p.instuctions          = prog.instuctions;
    p.data                 = data;
    p.data_address         = addr;
    return p;
  endfunction

endpackage

// File: rtl/organization_stage_mt_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the pointer; the
// pointer moves to the slot after the winner whenever a grant is taken.
module organization_stage_mt_rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         grant_any
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  int            j;

  always_comb begin
    grant     = '0;
    gidx      = ptr;
    grant_any = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!grant_any && req[j]) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        gidx      = PW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance && grant_any) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/organization_stage_mt.sv
// Multi-thread organization stage: parks issued thread programs per thread_id, merges read
// returns by receive_id, and streams completed slots to execution in round-robin order.
module organization_stage_mt
  import organization_stage_mt_pkg::*;
#(
  parameter int NUM_THREADS = 8,
  parameter int NUM_RET     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  thread_program_stuct_t              issue_thread,
  input  thread_id_t                         issue_id,
  input  logic                               issue_need_data,
  input  read_return_t [NUM_RET-1:0]         ret,
  output logic                               out_valid,
  input  logic                               out_ready,
  output pipeline_pass_structure             out_ev,
  output logic                               err_orphan,
  output logic [$clog2(NUM_THREADS+1)-1:0]   pending_count
);

  localparam int CW = $clog2(NUM_THREADS + 1);

  org_slot_t slot     [NUM_THREADS];
  org_slot_t slot_nxt [NUM_THREADS];

  logic                   issue_fire;
  logic                   load;
  logic [NUM_THREADS-1:0] req;
  logic [NUM_THREADS-1:0] grant;
  logic                   grant_any;
  thread_id_t             gidx;
  logic [NUM_RET-1:0]     drop;
  logic                   hit;
  logic [DATA_W-1:0]      hit_data;
  logic [ADDR_W-1:0]      hit_addr;
  logic                   dup;
  logic                   elig;
  logic [CW-1:0]          cnt_nxt;

  assign issue_ready = (slot[issue_id].state == SLOT_FREE);
  assign issue_fire  = issue_valid && issue_ready;
  assign load        = !out_valid || out_ready;

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) req[i] = (slot[i].state == SLOT_DONE);
  end

  organization_stage_mt_rr_arbiter #(.N(NUM_THREADS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (load),
    .grant     (grant),
    .grant_any (grant_any)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (grant[i]) gidx = thread_id_t'(i);
    end
  end

  // A return is kept only if its slot is waiting (or being issued with need_data this
  // cycle) and no lower channel already targets the same id.
  always_comb begin
    drop = '0;
    dup  = 1'b0;
    elig = 1'b0;
    for (int c = 0; c < NUM_RET; c++) begin
      dup = 1'b0;
      for (int k = 0; k < c; k++) begin
        if (ret[k].valid && (ret[k].receive_id == ret[c].receive_id)) dup = 1'b1;
      end
      elig = (slot[ret[c].receive_id].state == SLOT_WAIT) ||
             (issue_fire && issue_need_data && (issue_id == ret[c].receive_id));
      drop[c] = ret[c].valid && (dup || !elig);
    end
  end

  // Slot FSM next state
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    hit_addr = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      slot_nxt[i] = slot[i];
      hit      = 1'b0;
      hit_data = '0;
      hit_addr = '0;
      for (int c = 0; c < NUM_RET; c++) begin
        if (!hit && ret[c].valid && (ret[c].receive_id == thread_id_t'(i))) begin
          hit      = 1'b1;
          hit_data = ret[c].data;
          hit_addr = ret[c].read_address;
        end
      end
      case (slot[i].state)
        SLOT_FREE: begin
          if (issue_fire && (issue_id == thread_id_t'(i))) begin
            slot_nxt[i].prog = issue_thread;
            if (!issue_need_data) begin
              slot_nxt[i].state        = SLOT_DONE;
              slot_nxt[i].data         = '0;
              slot_nxt[i].read_address = '0;
            end else if (hit) begin
              slot_nxt[i].state        = SLOT_DONE;
              slot_nxt[i].data         = hit_data;
              slot_nxt[i].read_address = hit_addr;
            end else begin
              slot_nxt[i].state = SLOT_WAIT;
            end
          end
        end
        SLOT_WAIT: begin
          if (hit) begin
            slot_nxt[i].state        = SLOT_DONE;
            slot_nxt[i].data         = hit_data;
            slot_nxt[i].read_address = hit_addr;
          end
        end
        SLOT_DONE: begin
          if (load && grant[i]) slot_nxt[i].state = SLOT_FREE;
        end
        default: slot_nxt[i].state = SLOT_FREE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (slot_nxt[i].state != SLOT_FREE) cnt_nxt = cnt_nxt + CW'(1);
    end
  end

  // Slot state register; payload fields carry no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      slot[i].prog         <= slot_nxt[i].prog;
      slot[i].data         <= slot_nxt[i].data;
      slot[i].read_address <= slot_nxt[i].read_address;
      slot[i].state        <= rst ? slot_nxt[i].state : SLOT_FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_count <= '0;
      err_orphan    <= 1'b0;
    end else begin
      pending_count <= cnt_nxt;
      err_orphan    <= |drop;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_ev    <= '0;
    end else if (load) begin
      out_valid <= grant_any;
      if (grant_any) begin
        out_ev <= build_pass(slot[gidx].prog, slot[gidx].data, slot[gidx].read_address, gidx);
      end
    end
  end

endmodule
